// File: rtl/regfile_pkg.sv
// Shared register-bank definitions used by the bank and its writeback initiators.
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int REG_ZERO   = 0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] adr;
    logic [REG_DATA_W-1:0] value;
  } wb_entry_t;

endpackage

// File: rtl/regfile_write_queue_if.sv
// Producer, register-bank write port and forwarding lookup signals of the write queue.
interface regfile_write_queue_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);

  logic              alu_valid;
  logic [ADDR_W-1:0] alu_adr;
  logic [DATA_W-1:0] alu_value;
  logic              mem_valid;
  logic [ADDR_W-1:0] mem_adr;
  logic [DATA_W-1:0] mem_value;
  logic              full;
  logic [ADDR_W-1:0] wadr;
  logic [DATA_W-1:0] wvalue;
  logic              wenable;
  logic [ADDR_W-1:0] qadr;
  logic              qhit;
  logic [DATA_W-1:0] qvalue;
  logic              overflow;

  modport master (
    output alu_valid, alu_adr, alu_value,
    output mem_valid, mem_adr, mem_value,
    output qadr,
    input  full, wadr, wvalue, wenable, qhit, qvalue, overflow
  );

  modport slave (
    input  alu_valid, alu_adr, alu_value,
    input  mem_valid, mem_adr, mem_value,
    input  qadr,
    output full, wadr, wvalue, wenable, qhit, qvalue, overflow
  );

endinterface

// File: rtl/regfile_write_queue_match.sv
// Youngest-match search over the queued entries, ordered by age starting at rptr.
module wb_match_youngest
  import regfile_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DATA_W = REG_DATA_W,
  parameter int PTR_W  = $clog2(DEPTH),
  parameter int CNT_W  = PTR_W + 1
) (
  input  logic [ADDR_W-1:0] adr_mem   [DEPTH],
  input  logic [DATA_W-1:0] value_mem [DEPTH],
  input  logic [PTR_W-1:0]  rptr,
  input  logic [CNT_W-1:0]  count,
  input  logic [ADDR_W-1:0] qadr,
  output logic              qhit,
  output logic [DATA_W-1:0] qvalue
);

  logic [DEPTH-1:0]  age_hit;
  logic [DATA_W-1:0] age_value [DEPTH];

  // Slot gi of the age order is gi entries behind the head.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
    logic [PTR_W-1:0] idx;
    assign idx           = rptr + PTR_W'(gi);
    assign age_hit[gi]   = (CNT_W'(gi) < count) && (adr_mem[idx] == qadr) &&
                           (qadr != ADDR_W'(REG_ZERO));
    assign age_value[gi] = value_mem[idx];
  end

  // Later (younger) matches override earlier ones.
  always_comb begin
    qhit   = 1'b0;
    qvalue = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (age_hit[i]) begin
        qhit   = 1'b1;
        qvalue = age_value[i];
      end
    end
  end

endmodule

// File: rtl/regfile_write_queue.sv
// In-order writeback queue from the ALU and load unit into the register bank write port,
// draining one entry per clock and forwarding still-queued values to operand read.
module regfile_write_queue
  import regfile_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DATA_W = REG_DATA_W
) (
  input logic             clock,
  input logic             reset,
  regfile_write_queue_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_THRESH = CNT_W'(DEPTH - 2);

  logic [PTR_W-1:0]  rptr_reg, rptr_next;
  logic [PTR_W-1:0]  wptr_reg, wptr_next;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic              overflow_reg, overflow_next;

  logic [ADDR_W-1:0] adr_mem   [DEPTH];
  logic [DATA_W-1:0] value_mem [DEPTH];

  logic              alu_ok, mem_ok, full_int, pop;
  logic              push_alu, push_mem;
  logic [PTR_W-1:0]  mem_slot;
  logic [CNT_W-1:0]  push_cnt;

  always_comb begin
    alu_ok   = bus.alu_valid && (bus.alu_adr != ADDR_W'(REG_ZERO));
    mem_ok   = bus.mem_valid && (bus.mem_adr != ADDR_W'(REG_ZERO));
    full_int = count_reg > FULL_THRESH;
    push_alu = alu_ok && !full_int;
    push_mem = mem_ok && !full_int;
    // The load result lands behind the ALU result when both arrive together.
    mem_slot = push_alu ? wptr_reg + PTR_W'(1) : wptr_reg;
    pop      = count_reg != '0;
    push_cnt = CNT_W'(push_alu) + CNT_W'(push_mem);

    count_next    = count_reg + push_cnt - CNT_W'(pop);
    wptr_next     = wptr_reg + push_cnt[PTR_W-1:0];
    rptr_next     = rptr_reg + PTR_W'(pop);
    overflow_next = overflow_reg || (full_int && (alu_ok || mem_ok));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rptr_reg     <= '0;
      wptr_reg     <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      rptr_reg     <= rptr_next;
      wptr_reg     <= wptr_next;
      count_reg    <= count_next;
      overflow_reg <= overflow_next;
    end
  end

  // Entry storage needs no reset; validity is tracked by rptr/count alone.
  always_ff @(posedge clock) begin
    if (push_alu) begin
      adr_mem[wptr_reg]   <= bus.alu_adr;
      value_mem[wptr_reg] <= bus.alu_value;
    end
    if (push_mem) begin
      adr_mem[mem_slot]   <= bus.mem_adr;
      value_mem[mem_slot] <= bus.mem_value;
    end
  end

  assign bus.full     = full_int;
  assign bus.overflow = overflow_reg;
  assign bus.wenable  = pop;
  assign bus.wadr     = pop ? adr_mem[rptr_reg]   : '0;
  assign bus.wvalue   = pop ? value_mem[rptr_reg] : '0;

  wb_match_youngest #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .PTR_W  (PTR_W),
    .CNT_W  (CNT_W)
  ) u_match (
    .adr_mem   (adr_mem),
    .value_mem (value_mem),
    .rptr      (rptr_reg),
    .count     (count_reg),
    .qadr      (bus.qadr),
    .qhit      (bus.qhit),
    .qvalue    (bus.qvalue)
  );

endmodule
